// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared pixel width default, 3x3 window slice indices and window FSM state type
package cnn_pkg;

    localparam int PIX_W_DEF = 8;

    // Window slice index k = 3*r + c; r=0 is the oldest row, c=0 the leftmost column
    localparam int K_TL = 0;
    localparam int K_TM = 1;
    localparam int K_TR = 2;
    localparam int K_ML = 3;
    localparam int K_MM = 4;
    localparam int K_MR = 5;
    localparam int K_BL = 6;
    localparam int K_BM = 7;
    localparam int K_BR = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } win_state_t;

    function automatic int k_idx(input int r, input int c);
        return 3 * r + c;
    endfunction

endpackage

// File: rtl/pixel_window_gen_if.sv
// rtl/pixel_window_gen_if.sv - pixel stream in / 3x3 window out bundle (win_count present under WIN_COUNT_EN)
interface pixel_window_gen_if
    import cnn_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF
) ();

    logic               pixel_valid;
    logic [PIX_W-1:0]   pixel_in;
    logic               frame_start;
    logic               win_valid;
    logic [9*PIX_W-1:0] win_out;
    logic               frame_done;
`ifdef WIN_COUNT_EN
    logic [15:0]        win_count;
`endif

    // Pixel source / window consumer side
    modport master (
        output pixel_valid, pixel_in, frame_start,
`ifdef WIN_COUNT_EN
        input  win_count,
`endif
        input  win_valid, win_out, frame_done
    );

    // Window generator side
    modport slave (
        input  pixel_valid, pixel_in, frame_start,
`ifdef WIN_COUNT_EN
        output win_count,
`endif
        output win_valid, win_out, frame_done
    );

endinterface

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - single-port row buffer, combinational read of the old word, write on clock edge
module line_buffer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Read sees the pre-write contents of the same address in the write cycle
    assign rd_data = mem[addr];

    // Store the new word at the addressed column; contents are not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/pixel_window_gen.sv
// rtl/pixel_window_gen.sv - raster pixel stream to 3x3 sliding window generator; WIN_COUNT_EN adds win_count
module pixel_window_gen
    import cnn_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    pixel_window_gen_if.slave pw
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    win_state_t state, state_next;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          accept;
    logic          restart;
    logic [CW-1:0] pos_col;
    logic [RW-1:0] pos_row;
    logic          last_pix;
    logic          win_hit;

    logic [PIX_W-1:0]   lb0_rd;
    logic [PIX_W-1:0]   lb1_rd;
    logic [PIX_W-1:0]   sr      [3][3];
    logic [PIX_W-1:0]   sr_next [3][3];
    logic [9*PIX_W-1:0] win_next;
    logic               win_valid_q;
    logic               frame_done_q;
    logic [9*PIX_W-1:0] win_out_q;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: DONE is a single dead cycle before returning to IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ACTIVE;
            ACTIVE:  if (accept && last_pix) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: which pixels are taken, and which ones restart the frame at (0,0)
    always_comb begin
        accept  = 1'b0;
        restart = 1'b0;
        case (state)
            IDLE: begin
                if (pw.pixel_valid && pw.frame_start) begin
                    accept  = 1'b1;
                    restart = 1'b1;
                end
            end
            ACTIVE: begin
                if (pw.pixel_valid) begin
                    accept  = 1'b1;
                    restart = pw.frame_start;
                end
            end
            default: ;
        endcase
    end

    assign pos_col  = restart ? '0 : col;
    assign pos_row  = restart ? '0 : row;
    assign last_pix = (pos_row == ROW_LAST) && (pos_col == COL_LAST);
    assign win_hit  = (pos_row >= RW'(2)) && (pos_col >= CW'(2));

    // Row-1 buffer takes the live pixel; row-2 buffer takes what row-1 held at this column
    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(CW)) u_line0 (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (pos_col),
        .wr_data (pw.pixel_in),
        .rd_data (lb0_rd)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(CW)) u_line1 (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (pos_col),
        .wr_data (lb0_rd),
        .rd_data (lb1_rd)
    );

    // Column shift: drop the leftmost column, append {row-2, row-1, live} on the right
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 3; r++) begin
                sr_next[c][r] = sr[c+1][r];
            end
        end
        sr_next[2][0] = lb1_rd;
        sr_next[2][1] = lb0_rd;
        sr_next[2][2] = pw.pixel_in;
    end

    // Flatten the post-shift window into slice order k = 3*r + c
    always_comb begin
        win_next = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                win_next[k_idx(r, c)*PIX_W +: PIX_W] = sr_next[c][r];
            end
        end
    end

    // Window column registers advance on every accepted pixel
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int c = 0; c < 3; c++) begin
                for (int r = 0; r < 3; r++) begin
                    sr[c][r] <= sr_next[c][r];
                end
            end
        end
    end

    // Position counters hold the coordinate the next accepted pixel will take
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (last_pix) begin
                col <= '0;
                row <= '0;
            end else if (pos_col == COL_LAST) begin
                col <= '0;
                row <= pos_row + RW'(1);
            end else begin
                col <= pos_col + CW'(1);
                row <= pos_row;
            end
        end
    end

    // Registered outputs; win_out only changes when a full window is emitted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            win_out_q    <= '0;
        end else begin
            win_valid_q  <= accept && win_hit;
            frame_done_q <= accept && last_pix;
            if (accept && win_hit) begin
                win_out_q <= win_next;
            end
        end
    end

    assign pw.win_valid  = win_valid_q;
    assign pw.frame_done = frame_done_q;
    assign pw.win_out    = win_out_q;

`ifdef WIN_COUNT_EN
    logic [15:0] win_count_q;

    // Windows emitted in the current frame; cleared by an accepted frame_start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_count_q <= '0;
        end else if (accept && restart) begin
            win_count_q <= '0;
        end else if (accept && win_hit) begin
            win_count_q <= win_count_q + 16'd1;
        end
    end

    assign pw.win_count = win_count_q;
`endif

endmodule

// File: tb/tb_pixel_window_gen.sv
// tb/tb_pixel_window_gen.sv - self-checking bench for pixel_window_gen with an image-array reference model
module tb_pixel_window_gen;
    import cnn_pkg::*;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int PW = 8;

    logic clk;
    logic rst_n;

    pixel_window_gen_if #(.PIX_W(PW)) pif ();

    pixel_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pw    (pif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_pass;

    // Reference model: the frame as a 2D image, plus where the next pixel lands
    logic [PW-1:0]   img [H][W];
    bit              m_act;
    bit              m_done;
    int              mr, mc;
    logic            exp_wv, exp_fd;
    logic [9*PW-1:0] exp_win;
    int              exp_cnt;

    // Observations of DUT outputs within one scenario
    int              obs_nwin, obs_nfd;
    logic [9*PW-1:0] obs_first, obs_last;
    logic            obs_last_fd;
    bit              obs_stale;
    int              stale_hi;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [9*PW-1:0] mk_win(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        int v [9];
        logic [9*PW-1:0] w;
        v = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
        w = '0;
        for (int k = 0; k < 9; k++) w[k*PW +: PW] = PW'(v[k]);
        return w;
    endfunction

    task automatic m_reset();
        m_act = 0; m_done = 0; mr = 0; mc = 0;
        exp_wv = 0; exp_fd = 0; exp_win = '0; exp_cnt = 0;
    endtask

    task automatic clear_obs(input int hi);
        obs_nwin = 0; obs_nfd = 0; obs_first = '0; obs_last = '0;
        obs_last_fd = 0; obs_stale = 0; stale_hi = hi;
    endtask

    task automatic model_step(input bit v, input bit fs, input logic [PW-1:0] p);
        exp_wv = 0;
        exp_fd = 0;
        if (m_done) begin
            m_done = 0;
        end else if (v) begin
            if (fs) begin
                m_act = 1; mr = 0; mc = 0; exp_cnt = 0;
            end
            if (m_act) begin
                img[mr][mc] = p;
                if (mr >= 2 && mc >= 2) begin
                    exp_wv = 1;
                    exp_cnt++;
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            exp_win[(3*i+j)*PW +: PW] = img[mr-2+i][mc-2+j];
                end
                if (mr == H-1 && mc == W-1) begin
                    exp_fd = 1; m_act = 0; m_done = 1;
                    mr = 0; mc = 0;
                end else if (mc == W-1) begin
                    mc = 0; mr++;
                end else begin
                    mc++;
                end
            end
        end
    endtask

    task automatic send(input bit v, input bit fs, input logic [PW-1:0] p);
        pif.pixel_valid = v;
        pif.frame_start = fs;
        pif.pixel_in    = p;
        @(posedge clk);
        model_step(v, fs, p);
        @(negedge clk);
        check("win_valid", 96'(pif.win_valid), 96'(exp_wv));
        check("frame_done", 96'(pif.frame_done), 96'(exp_fd));
        check("win_out", 96'(pif.win_out), 96'(exp_win));
`ifdef WIN_COUNT_EN
        check("win_count", 96'(pif.win_count), 96'(exp_cnt));
`endif
        if (pif.win_valid) begin
            obs_nwin++;
            if (obs_nwin == 1) obs_first = pif.win_out;
            obs_last    = pif.win_out;
            obs_last_fd = pif.frame_done;
            for (int k = 0; k < 9; k++)
                if (pif.win_out[k*PW +: PW] >= 1 && int'(pif.win_out[k*PW +: PW]) <= stale_hi)
                    obs_stale = 1;
        end
        if (pif.frame_done) obs_nfd++;
        pif.pixel_valid = 1'b0;
        pif.frame_start = 1'b0;
    endtask

    task automatic feed(input int base, input int n, input bit first_fs, input bit gaps);
        for (int i = 0; i < n; i++) begin
            send(1'b1, first_fs && (i == 0), PW'(base + i));
            if (gaps) send(1'b0, 1'b0, PW'($urandom));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 1'b0, PW'($urandom));
    endtask

    task automatic check_basic_frame(input string tag);
        check({tag, "_nwin"}, 96'(obs_nwin), 96'd4);
        check({tag, "_first"}, 96'(obs_first), 96'(mk_win(1, 2, 3, 5, 6, 7, 9, 10, 11)));
        check({tag, "_last"}, 96'(obs_last), 96'(mk_win(6, 7, 8, 10, 11, 12, 14, 15, 16)));
        check({tag, "_last_fd"}, 96'(obs_last_fd), 96'd1);
        check({tag, "_nfd"}, 96'(obs_nfd), 96'd1);
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        pif.pixel_valid = 1'b0;
        pif.frame_start = 1'b0;
        pif.pixel_in    = '0;
        rst_n = 1'b0;
        m_reset();
        clear_obs(0);
        repeat (3) @(negedge clk);
        check("rst_win_valid", 96'(pif.win_valid), 96'd0);
        check("rst_frame_done", 96'(pif.frame_done), 96'd0);
        check("rst_win_out", 96'(pif.win_out), 96'd0);
        rst_n = 1'b1;
        idle(2);

        // Back-to-back frame 1..16
        clear_obs(0);
        feed(1, 16, 1'b1, 1'b0);
`ifdef WIN_COUNT_EN
        check("cnt_after_frame", 96'(pif.win_count), 96'd4);
`endif
        idle(3);
        check_basic_frame("b2b");

        // Same frame with a bubble after every pixel
        clear_obs(0);
        feed(1, 16, 1'b1, 1'b1);
`ifdef WIN_COUNT_EN
        check("cnt_after_gap_frame", 96'(pif.win_count), 96'd4);
`endif
        idle(3);
        check_basic_frame("gaps");

        // Pixels without frame_start in IDLE are dropped
        clear_obs(0);
        for (int i = 1; i <= 6; i++) send(1'b1, 1'b0, PW'(i));
        check("idle_drop_nwin", 96'(obs_nwin), 96'd0);
        feed(1, 16, 1'b1, 1'b0);
        idle(3);
        check_basic_frame("idle_drop");

        // Mid-frame restart: old partial rows must never reach a window
        clear_obs(10);
        feed(1, 10, 1'b1, 1'b0);
        feed(101, 16, 1'b1, 1'b0);
        idle(3);
        check("restart_nwin", 96'(obs_nwin), 96'd4);
        check("restart_first", 96'(obs_first),
              96'(mk_win(101, 102, 103, 105, 106, 107, 109, 110, 111)));
        check("restart_nfd", 96'(obs_nfd), 96'd1);
        check("restart_stale", 96'(obs_stale), 96'd0);

        // Asynchronous reset mid-frame, then a clean frame
        clear_obs(0);
        feed(1, 9, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_win_valid", 96'(pif.win_valid), 96'd0);
        check("arst_frame_done", 96'(pif.frame_done), 96'd0);
        check("arst_win_out", 96'(pif.win_out), 96'd0);
`ifdef WIN_COUNT_EN
        check("arst_win_count", 96'(pif.win_count), 96'd0);
`endif
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        clear_obs(0);
        for (int i = 10; i <= 16; i++) send(1'b1, 1'b0, PW'(i));
        check("post_rst_no_fs_nwin", 96'(obs_nwin), 96'd0);
        feed(1, 16, 1'b1, 1'b0);
        idle(3);
        check_basic_frame("post_rst");

        // Valid pixel in the DONE cycle is dropped, frame_start included
        clear_obs(0);
        feed(1, 16, 1'b1, 1'b0);
        send(1'b1, 1'b1, 8'hEE);
        idle(2);
        check("done_drop_nwin", 96'(obs_nwin), 96'd4);

        // Random traffic: random values, gaps, frame_starts and restarts
        clear_obs(0);
        for (int i = 0; i < 600; i++) begin
            automatic bit v  = ($urandom % 3) != 0;
            automatic bit fs = v && (($urandom % 30) == 0);
            send(v, fs, PW'($urandom));
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pixel_window_gen.md
PIXEL_WINDOW_GEN -- requirements
Module: pixel_window_gen

Interface
REQ-001 Parameter IMG_W, default 8: pixels per image row, range 3..256.
REQ-002 Parameter IMG_H, default 8: rows per frame, range 3..256.
REQ-003 Parameter PIX_W, default 8: pixel width in bits.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 pixel_valid  input  1  pixel_in carries a pixel this cycle.
REQ-007 pixel_in  input  PIX_W  raster-order pixel stream, the same stream cnn_top consumes.
REQ-008 frame_start  input  1  qualified by pixel_valid; marks pixel (row 0, col 0).
REQ-009 win_valid  output  1  win_out holds a complete 3x3 window.
REQ-010 win_out  output  9*PIX_W  window; slice k = 3*r + c; r=0 is the oldest row; c=0 is the leftmost column; k=8 is the newest pixel.
REQ-011 frame_done  output  1  one-cycle pulse when a frame completes.

Function
REQ-012 FSM states: IDLE, ACTIVE, DONE.
REQ-013 In IDLE, pixels without frame_start are dropped.
REQ-014 In IDLE, a pixel with frame_start is accepted as (0,0), and the FSM moves to ACTIVE.
REQ-015 In ACTIVE, each pixel_valid pixel is accepted; col increments and wraps at IMG_W-1, and row increments on that wrap.
REQ-016 Cycles with pixel_valid=0 hold all state; gaps of any length are legal.
REQ-017 Two line buffers of IMG_W x PIX_W each hold the previous two rows; they are written at the column of each accepted pixel.
REQ-018 A 3x3 shift register of columns is loaded from the {line1, line0, pixel_in} column on each accept.
REQ-019 win_valid is registered: it is 1 in the cycle after accepting pixel (row,col) if and only if row>=2 and col>=2, and 0 otherwise.
REQ-020 Latency from pixel accept to window is 1 clock; exactly (IMG_W-2)*(IMG_H-2) windows are produced per frame.
REQ-021 No window spans a row boundary.
REQ-022 win_out holds its last value when win_valid=0.
REQ-023 Accepting pixel (IMG_H-1, IMG_W-1) moves the FSM to DONE, and frame_done=1 in the same cycle as the final win_valid.
REQ-024 DONE lasts exactly one cycle, then the FSM returns to IDLE; pixels in that DONE cycle are dropped.
REQ-025 If frame_start arrives in ACTIVE, that pixel restarts the frame as (0,0): counters reset, no window or frame_done is produced for it, and stale line-buffer contents are never emitted.
REQ-026 win_valid and frame_done are never asserted in IDLE without an accepted pixel causing them.

Reset
REQ-027 rst_n=0 asynchronously forces: FSM to IDLE; row, col, win_valid, frame_done to 0; win_out to 0.
REQ-028 Line-buffer contents need not be reset.
REQ-029 Deasserting rst_n mid-frame discards the partial frame; the next frame requires frame_start.

Configuration
REQ-030 Macro WIN_COUNT_EN, when defined, adds output win_count (16 bits): the number of windows emitted in the current frame, cleared on frame_start and on reset, and held after frame_done.
REQ-031 Without WIN_COUNT_EN, the win_count port and its logic are absent, and all other behaviour is identical.

Structure
REQ-032 Shared package cnn_pkg holds the PIX_W default, the window slice index constants (K_TL..K_BR), and the FSM state enum typedef.
REQ-033 One sub-module, line_buffer (single-port, IMG_W deep, read-before-write), is instantiated twice.

Verification
All scenarios use IMG_W=4, IMG_H=4.
REQ-034 Feed pixels 1..16 back-to-back with frame_start on pixel 1:
- exactly 4 windows are produced;
- the first window is {1,2,3,5,6,7,9,10,11}, one cycle after pixel 11;
- the last window is {6,7,8,10,11,12,14,15,16], with frame_done=1 in the same cycle.
REQ-035 Repeat the REQ-034 stimulus with pixel_valid=0 inserted every other cycle: identical window contents, each arriving 1 cycle after its triggering pixel.
REQ-036 Send pixels 1..6 without frame_start while in IDLE, then 1..16 with frame_start: the output is identical to REQ-034.
REQ-037 Send pixels 1..10, then frame_start with pixels 101..116: no window contains values 1..10, the first window is {101,102,103,105,106,107,109,110,111}, and exactly one frame_done is produced.
REQ-038 Pulse rst_n low after pixel 9: all outputs are 0 immediately, and the following frame behaves as in REQ-034.
REQ-039 With WIN_COUNT_EN defined: win_count reads 4 after REQ-034 and returns to 0 on the next frame_start.
